// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of a 4-bit combinational ALU: queues {chain, op, b, a} commands and issues them one at a time.
// Latency: a command accepted at edge N drives alu_* after N+1, and res_valid rises at N+2. Best case is one result per 2 cycles.
// Backpressure: a held result stalls issue; the FIFO then fills and cmd_ready drops (it is derived from registered state only).
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready, cmd_a/b/op  command push handshake and payload
//   cmd_chain                        when set, operand a comes from the last captured result
//   alu_a/alu_b/alu_op               registered operands to the external ALU
//   alu_y, alu_zero/overflow/carry/equal  ALU result and flags
//   res_valid/res_ready, res_y, res_flags  held result {equal, carry, overflow, zero}
//   op_count, busy                   completed handshakes, activity indicator
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_chain,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_op,
    input  logic [3:0]       alu_y,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_equal,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_y,
    output logic [3:0]       res_flags,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state_q, state_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [11:0]      mem_q [DEPTH];
    logic [11:0]      mem_d [DEPTH];
    logic [3:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [3:0]       res_y_q, res_y_d, res_flags_q, res_flags_d;
    logic             res_valid_q, res_valid_d;
    logic [3:0]       last_y_q, last_y_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic        empty, full, push, pop;
    logic [11:0] head;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = cmd_valid && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // The next command issues from IDLE, or from HOLD in the same edge as the result handshake.
    assign pop = !empty && ((state_q == IDLE) || ((state_q == HOLD) && res_ready));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        res_y_d     = res_y_q;
        res_flags_d = res_flags_q;
        res_valid_d = res_valid_q;
        last_y_d    = last_y_q;
        op_count_d  = op_count_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {cmd_chain, cmd_op, cmd_b, cmd_a};
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end

        case (state_q)
            EXEC: begin
                res_y_d     = alu_y;
                last_y_d    = alu_y;
                res_flags_d = {alu_equal, alu_carry, alu_overflow, alu_zero};
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            // Chain reads last_y_q: the previous result is always captured before the next issue.
            alu_a_d  = head[11] ? last_y_q : head[3:0];
            alu_b_d  = head[7:4];
            alu_op_d = head[10:8];
            state_d  = EXEC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            res_y_q     <= '0;
            res_flags_q <= '0;
            res_valid_q <= 1'b0;
            last_y_q    <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            res_y_q     <= res_y_d;
            res_flags_q <= res_flags_d;
            res_valid_q <= res_valid_d;
            last_y_q    <= last_y_d;
            op_count_q  <= op_count_d;
        end
        // Storage holds payload only; emptiness lives in the pointers.
        mem_q <= mem_d;
    end

    assign cmd_ready = !full;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_flags = res_flags_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q != IDLE) || !empty;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives the result inputs, and a scoreboard of expected results
// is filled at command acceptance and drained by a monitor on every result handshake.
// Directed scenarios cover reset, latency, chaining, backpressure, mid-stream reset and op_count wrap, plus a random phase.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic       cmd_chain = 1'b0;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_y;
    logic       alu_zero, alu_overflow, alu_carry, alu_equal;
    logic       res_valid, res_ready;
    logic [3:0] res_y, res_flags;
    logic [7:0] op_count;
    logic       busy;

    logic rdy_force = 1'b1;
    logic rand_rdy  = 1'b0;
    logic rnd_bit   = 1'b0;
    assign res_ready = rand_rdy ? rnd_bit : rdy_force;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] y;
        logic [3:0] flags;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_last = '0;
    logic [7:0] exp_cnt = '0;
    int         total = 0;
    int         bad = 0;

    // Reference ALU: returns {equal, carry, overflow, zero, y}. Opcode 7 is a compare that yields y=0.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] y;
        logic c, v, e;
        c = 1'b0; v = 1'b0; e = 1'b0; y = '0; s = '0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[3:0]; c = s[4];
                        v = (a[3] == b[3]) && (y[3] != a[3]); end
            3'd1: begin y = a - b; c = (a < b); v = (a[3] != b[3]) && (y[3] != a[3]); end
            3'd2: y = a & b;
            3'd3: y = a | b;
            3'd4: y = a ^ b;
            3'd5: y = ~a;
            3'd6: begin y = {a[2:0], 1'b0}; c = a[3]; end
            default: begin y = 4'd0; e = (a == b); end
        endcase
        return {e, c, v, (op != 3'd7) && (y == 4'd0), y};
    endfunction

    assign {alu_equal, alu_carry, alu_overflow, alu_zero, alu_y} = alu_f(alu_a, alu_b, alu_op);

    alu_issue_ctrl #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_equal(alu_equal),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_flags(res_flags),
        .op_count(op_count), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk); #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation ran past cycle budget, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Model: results come out in order, so a chained command uses the previous accepted command's result.
    task automatic model_push(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic ch);
        exp_t       e;
        logic [7:0] r;
        e.a = ch ? m_last : a;
        e.b = b;
        e.op = op;
        r = alu_f(e.a, b, op);
        e.y = r[3:0];
        e.flags = r[7:4];
        m_last = r[3:0];
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake must match the oldest expected result and the running handshake count.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            exp_cnt = '0;
        end else if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_pkt", int'({alu_a, alu_b, alu_op, res_y, res_flags}),
                    int'({e.a, e.b, e.op, e.y, e.flags}));
                chk("op_count_at_hs", int'(op_count), int'(exp_cnt));
                exp_cnt = exp_cnt + 8'd1;
            end
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic ch);
        int  n;
        bit  done;
        n = 0; done = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = ch;
        while (!done) begin
            @(negedge clk);
            if (cmd_ready) begin
                model_push(a, b, op, ch);
                done = 1;
            end else if (++n > 200) begin
                chk("send_timeout", 0, 1);
                done = 1;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(exp_q.size() != 0 || busy), 0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        m_last = '0;
    endtask

    initial begin
        int acc;
        logic [3:0] held_y;

        // Reset held two cycles with a command offered: nothing may be queued.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_a = 4'd1; cmd_b = 4'd2;
        do_reset(2);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_alu_regs", int'({alu_a, alu_b, alu_op}), 0);
        chk("rst_busy", int'(busy), 0);

        // Single op with latency checks: alu_* after N+1, res_valid after N+2.
        rdy_force = 1'b1;
        send(4'd3, 4'd4, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("lat_alu_ab", int'({alu_a, alu_b}), int'({4'd3, 4'd4}));
        chk("lat_res_valid_n1", int'(res_valid), 0);
        @(negedge clk);
        chk("lat_res_valid_n2", int'(res_valid), 1);
        chk("single_res_y", int'(res_y), 7);
        wait_drain("drain_single");
        chk("single_op_count", int'(op_count), 1);

        // Equal compare and a chained pair.
        send(4'd5, 4'd5, 3'd7, 1'b0);
        wait_drain("drain_cmp");
        send(4'd2, 4'd3, 3'd0, 1'b0);
        send(4'd9, 4'd1, 3'd1, 1'b1);
        wait_drain("drain_chain");
        chk("chain_final_y", int'(res_y), 4);

        // Backpressure: one held plus DEPTH queued, then cmd_ready drops and res_y is held.
        rdy_force = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b1;
            cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 3'($urandom); cmd_chain = 1'($urandom);
            @(negedge clk);
            if (cmd_ready) begin
                model_push(cmd_a, cmd_b, cmd_op, cmd_chain);
                acc++;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        held_y = exp_q[0].y;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", int'(cmd_ready), 0);
            chk("bp_res_held", int'({res_valid, res_y}), int'({1'b1, held_y}));
        end
        @(posedge clk); #1;
        rdy_force = 1'b1;
        acc = 0;
        while (exp_q.size() != 0 && acc < 50) begin
            @(negedge clk);
            acc++;
        end
        chk("bp_drain_cycles", acc, 9);
        wait_drain("drain_bp");

        // Random traffic with random consumer stalls and chaining.
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        wait_drain("drain_random");

        // Mid-stream reset: one held, three queued, then everything is discarded.
        rdy_force = 1'b0;
        for (int i = 0; i < 4; i++) send(4'(i + 1), 4'd1, 3'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_pre_valid", int'(res_valid), 1);
        do_reset(1);
        @(negedge clk);
        chk("mid_res_valid", int'(res_valid), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_op_count", int'(op_count), 0);
        chk("mid_cmd_ready", int'(cmd_ready), 1);
        rdy_force = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) acc++;
        end
        chk("mid_no_results", acc, 0);

        // op_count wrap: 256 handshakes from reset bring it back to zero.
        for (int i = 0; i < 255; i++) send(4'($urandom), 4'($urandom), 3'($urandom), 1'b0);
        wait_drain("drain_wrap255");
        chk("wrap_255", int'(op_count), 255);
        send(4'd1, 4'd1, 3'd0, 1'b0);
        wait_drain("drain_wrap256");
        chk("wrap_0", int'(op_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 4-bit ALU. Buffers operand/opcode commands in a small FIFO and issues one at a time on registered ALU inputs.
- Captures the ALU result and its four flags into a held output with a valid/ready handshake.
- Optional chaining replaces operand a with the previous result, so multi-step arithmetic runs without an external round trip.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_a  in  4  operand a.
- cmd_b  in  4  operand b.
- cmd_op  in  3  ALU opcode, passed through unmodified.
- cmd_chain  in  1  1 = use last captured result as operand a; cmd_a is ignored.
- alu_a  out  4  registered operand a to the ALU.
- alu_b  out  4  registered operand b to the ALU.
- alu_op  out  3  registered opcode to the ALU.
- alu_y  in  4  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_overflow  in  1  ALU overflow flag.
- alu_carry  in  1  ALU carry flag.
- alu_equal  in  1  ALU compare/equal flag.
- res_valid  out  1  result held.
- res_ready  in  1  consumer accepts the result.
- res_y  out  4  captured result.
- res_flags  out  4  {equal, carry, overflow, zero}, captured in the same cycle as res_y.
- op_count  out  CNT_W  count of completed result handshakes.
- busy  out  1  FSM not in IDLE, or FIFO not empty.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM to IDLE, FIFO emptied.
  - alu_a/alu_b/alu_op = 0, res_y/res_flags = 0, res_valid = 0, op_count = 0, last_y = 0.
  - cmd_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards queued, in-flight and held results; no partial handshake completes.
- Command FIFO:
  - Push when cmd_valid & cmd_ready. Each entry stores {chain, op, b, a}.
  - cmd_ready = !full, derived from registered state only. A pop in the same cycle does not raise ready.
  - Read/write pointers are log2(DEPTH)+1 bits; wrap-around is handled by the extra bit.
  - Simultaneous push and pop when non-empty and not full: both take effect and occupancy is unchanged.
  - Data pushed at edge N is poppable no earlier than edge N+1; no fall-through.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE: if FIFO non-empty, pop head and load alu_a = chain ? last_y : a, alu_b = b, alu_op = op; go to EXEC. Otherwise stay.
  - EXEC: ALU is combinational from alu_* registers. Capture alu_y into res_y and last_y, capture flags into res_flags, set res_valid = 1, go to HOLD.
  - HOLD: res_y, res_flags and alu_* are stable while res_valid & !res_ready.
  - HOLD on handshake (res_ready = 1):
    - clear res_valid and increment op_count (wraps 2^CNT_W-1 -> 0);
    - if FIFO non-empty, pop and issue in the same edge and go to EXEC;
    - else go to IDLE.
- Latency: command accepted at edge N issues at edge N+1; res_valid rises at edge N+2.
- Throughput: best case one result per 2 cycles.
- Chaining always uses the most recently captured result, even if not yet handshaken. A chain command with no prior result since reset uses last_y = 0.
- Flags pass through unmodified; this block never reinterprets opcodes.
- busy = (state != IDLE) | !empty.

Test Plan:
- Reset: hold rst 2 cycles with cmd_valid=1 -> no push; after release cmd_ready=1, res_valid=0, op_count=0, alu_a/b/op=0.
- Single op: push a=3, b=4, op=000 at edge N, res_ready=1 -> alu_a=3, alu_b=4 after N+1; res_valid=1, res_y=7, res_flags[0]=0 after N+2; op_count=1 after the handshake.
- Equal compare: push a=5, b=5, op=111 -> res_y=0, res_flags=4'b1000.
- Chain: push (2,3,op 000) then (chain=1, a=9, b=1, op 001) -> second issue has alu_a=5, final res_y=4.
- Backpressure: res_ready=0, DEPTH=4, push continuously -> 5 commands accepted (1 held in HOLD plus 4 queued), then cmd_ready=0. res_y stays at the first result until res_ready=1. Results then drain in order, one per 2 cycles.
- Reset mid-stream: 3 queued plus 1 held, assert rst one cycle -> res_valid=0, busy=0, no further results emitted; op_count: 255 handshakes with CNT_W=8 then one more -> op_count=0.
